// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman front end: alphabet size, default slot
// count and frequency width, the frequency-counter state encoding and the
// (ascii, freq) slot record used by the top-N list.
package huff_pkg;

  localparam int unsigned ALPHABET_SIZE = 256;
  localparam int unsigned NUM_SLOTS     = 6;
  localparam int unsigned FREQ_W        = 32;
  localparam int unsigned SYM_W         = 8;
  // Slot records always carry the full-width frequency; narrower counters
  // are zero-extended into them.
  localparam int unsigned SLOT_FREQ_W   = FREQ_W;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_COUNT,
    ST_SCAN,
    ST_LOAD,
    ST_START
  } state_e;

  typedef struct packed {
    logic [SYM_W-1:0]       ascii;
    logic [SLOT_FREQ_W-1:0] freq;
  } slot_t;

endpackage

// File: rtl/huff_topn_insert.sv
// Combinational sorted insertion of one (ascii, freq) candidate into an
// N-entry list kept ascending by frequency.
//   list_i/cnt_i : current list and number of valid entries
//   cand_i       : candidate visited this cycle
//   list_o/cnt_o : list after the candidate is (possibly) inserted
// A zero-count candidate is never inserted. When the list is full the
// candidate must strictly beat the minimum; the evicted entry is the last of
// the equal-minimum run, so among tied minima the lower ASCII code survives.
module huff_topn_insert
  import huff_pkg::*;
#(
  parameter int unsigned N = NUM_SLOTS
) (
  input  slot_t      list_i [N],
  input  logic [7:0] cnt_i,
  input  slot_t      cand_i,
  output slot_t      list_o [N],
  output logic [7:0] cnt_o
);

  slot_t kept [N];
  logic  full;
  logic  ins;
  int    le_n;
  int    min_n;
  int    evict;
  int    pos;

  always_comb begin
    full  = (cnt_i == 8'(N));
    le_n  = 0;
    min_n = 0;
    for (int j = 0; j < int'(N); j++) begin
      if (j < int'(cnt_i)) begin
        if (list_i[j].freq <= cand_i.freq) le_n = le_n + 1;
        if (list_i[j].freq == list_i[0].freq) min_n = min_n + 1;
      end
    end

    ins   = (cand_i.freq != '0) && (!full || (cand_i.freq > list_i[0].freq));
    evict = (full && ins) ? (min_n - 1) : int'(N);
    // The evicted entry is always counted in le_n, so drop it from the position.
    pos   = full ? (le_n - 1) : le_n;

    // Remove the evicted entry by closing the gap.
    for (int j = 0; j < int'(N); j++) kept[j] = list_i[j];
    for (int j = 0; j < int'(N) - 1; j++) begin
      if (j >= evict) kept[j] = list_i[j+1];
    end

    // Insert after every entry whose count is <= the candidate's.
    list_o[0] = (ins && (pos == 0)) ? cand_i : kept[0];
    for (int i = 1; i < int'(N); i++) begin
      if (!ins || (i < pos)) list_o[i] = kept[i];
      else if (i == pos)     list_o[i] = cand_i;
      else                   list_o[i] = kept[i-1];
    end

    cnt_o = (ins && !full) ? (cnt_i + 8'd1) : cnt_i;
  end

endmodule

// File: rtl/huff_freq_counter.sv
// Huffman front end: counts byte occurrences over one message, keeps the
// NUM_SLOTS most frequent symbols and loads them, ascending by frequency,
// into the table builder's node queue, then strobes the builder.
//   clk, ctrl_reset_n          : clock, async active-low reset
//   in_valid/in_byte/in_last   : message byte stream (in_last marks final byte)
//   in_ready                   : high only while counting
//   ctrl_wrAscii/wrAscii/wrFreq/wrQueuePos : per-slot queue write ports
//   ctrl_start                 : one-cycle builder start (only if sym_count>0)
//   sym_count                  : number of valid slots in the last load
//   done                       : one-cycle end-of-message pulse
module huff_freq_counter
  import huff_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = huff_pkg::NUM_SLOTS,
  parameter int unsigned FREQ_W    = huff_pkg::FREQ_W
) (
  input  logic              clk,
  input  logic              ctrl_reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ctrl_wrAscii [0:NUM_SLOTS-1],
  output logic [7:0]        wrAscii      [0:NUM_SLOTS-1],
  output logic [FREQ_W-1:0] wrFreq       [0:NUM_SLOTS-1],
  output logic [7:0]        wrQueuePos   [0:NUM_SLOTS-1],
  output logic              ctrl_start,
  output logic [7:0]        sym_count,
  output logic              done
);

  localparam int unsigned IDX_W = $clog2(ALPHABET_SIZE);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FREQ_W-1:0] count_q [ALPHABET_SIZE];

  slot_t             list_q [NUM_SLOTS];
  slot_t             list_d [NUM_SLOTS];
  slot_t             ins_list_c [NUM_SLOTS];
  logic [7:0]        list_cnt_q, list_cnt_d, ins_cnt_c;
  slot_t             cand_c;

  logic              in_ready_q, in_ready_d;
  logic              slot_en_q    [NUM_SLOTS];
  logic              slot_en_d    [NUM_SLOTS];
  logic [7:0]        slot_ascii_q [NUM_SLOTS];
  logic [7:0]        slot_ascii_d [NUM_SLOTS];
  logic [FREQ_W-1:0] slot_freq_q  [NUM_SLOTS];
  logic [FREQ_W-1:0] slot_freq_d  [NUM_SLOTS];
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic [7:0]        sym_count_q, sym_count_d;

  logic              cnt_we_c;
  logic [IDX_W-1:0]  cnt_waddr_c;
  logic [FREQ_W-1:0] cnt_wdata_c;
  logic [FREQ_W-1:0] rd_byte_c;

  // Count storage: combinational read, one synchronous write per cycle.
  assign rd_byte_c = count_q[in_byte];
  assign cand_c    = {idx_q, SLOT_FREQ_W'(count_q[idx_q])};

  always_ff @(posedge clk) begin
    if (cnt_we_c) count_q[cnt_waddr_c] <= cnt_wdata_c;
  end

  huff_topn_insert #(.N(NUM_SLOTS)) u_insert (
    .list_i (list_q),
    .cnt_i  (list_cnt_q),
    .cand_i (cand_c),
    .list_o (ins_list_c),
    .cnt_o  (ins_cnt_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      list_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      sym_count_q <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        list_q[i]       <= '0;
        slot_en_q[i]    <= 1'b0;
        slot_ascii_q[i] <= '0;
        slot_freq_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      list_q       <= list_d;
      list_cnt_q   <= list_cnt_d;
      in_ready_q   <= in_ready_d;
      start_q      <= start_d;
      done_q       <= done_d;
      sym_count_q  <= sym_count_d;
      slot_en_q    <= slot_en_d;
      slot_ascii_q <= slot_ascii_d;
      slot_freq_q  <= slot_freq_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    list_d       = list_q;
    list_cnt_d   = list_cnt_q;
    in_ready_d   = 1'b0;
    start_d      = 1'b0;
    done_d       = 1'b0;
    sym_count_d  = sym_count_q;
    slot_ascii_d = slot_ascii_q;
    slot_freq_d  = slot_freq_q;
    for (int i = 0; i < int'(NUM_SLOTS); i++) slot_en_d[i] = 1'b0;
    cnt_we_c     = 1'b0;
    cnt_waddr_c  = idx_q;
    cnt_wdata_c  = '0;

    case (state_q)
      ST_CLEAR: begin
        cnt_we_c   = 1'b1;
        list_cnt_d = '0;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(ALPHABET_SIZE - 1)) begin
          state_d    = ST_COUNT;
          in_ready_d = 1'b1;
        end
      end

      ST_COUNT: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          cnt_we_c    = 1'b1;
          cnt_waddr_c = in_byte;
          cnt_wdata_c = (rd_byte_c == '1) ? rd_byte_c : (rd_byte_c + FREQ_W'(1));
          if (in_last) begin
            state_d    = ST_SCAN;
            in_ready_d = 1'b0;
          end
        end
      end

      ST_SCAN: begin
        list_d     = ins_list_c;
        list_cnt_d = ins_cnt_c;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(ALPHABET_SIZE - 1)) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
          if (8'(i) < list_cnt_q) begin
            slot_en_d[i]    = 1'b1;
            slot_ascii_d[i] = list_q[i].ascii;
            slot_freq_d[i]  = FREQ_W'(list_q[i].freq);
          end else begin
            slot_ascii_d[i] = '0;
            slot_freq_d[i]  = '0;
          end
        end
        sym_count_d = list_cnt_q;
        state_d     = ST_START;
      end

      ST_START: begin
        start_d = (sym_count_q != 8'd0);
        done_d  = 1'b1;
        state_d = ST_CLEAR;
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  assign in_ready     = in_ready_q;
  assign ctrl_wrAscii = slot_en_q;
  assign wrAscii      = slot_ascii_q;
  assign wrFreq       = slot_freq_q;
  assign ctrl_start   = start_q;
  assign sym_count    = sym_count_q;
  assign done         = done_q;

  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_pos
    assign wrQueuePos[g] = 8'(g);
  end

endmodule
